pipeline_hazard_ctrl: RTL

Central hazard and sequencing controller for the five-stage pipelined MIPS core. It drives the write-enable and flush/bubble inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, and produces the EX-stage forwarding selects. It also runs a data-memory wait state machine with a watchdog. One instance sits beside the datapath; all pipeline registers take their hold/flush controls from it.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 16 +
 rtl/pipeline_hazard_ctrl_if.sv | 39 +++
 rtl/pipeline_hazard_ctrl_forward_unit.sv | 19 +
 rtl/pipeline_hazard_ctrl.sv | 111 +++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle; the controller uses the slave view.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       if_id_rs, if_id_rt;
  logic [4:0]       id_ex_rs, id_ex_rt;
  logic             id_ex_memread;
  logic             ex_mem_regwrite;
  logic [4:0]       ex_mem_rd;
  logic             mem_wb_regwrite;
  logic [4:0]       mem_wb_rd;
  logic             ex_mem_memaccess;
  logic             dmem_ready;
  logic             branch_taken;
  logic             pc_we, if_id_we, id_ex_we, ex_mem_we;
  logic             if_id_flush, id_ex_flush, ex_mem_flush;
  logic             mem_wb_bubble;
  logic [1:0]       fwd_a, fwd_b;
  logic             dmem_err;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output if_id_rs, if_id_rt, id_ex_rs, id_ex_rt, id_ex_memread,
           ex_mem_regwrite, ex_mem_rd, mem_wb_regwrite, mem_wb_rd,
           ex_mem_memaccess, dmem_ready, branch_taken,
    input  pc_we, if_id_we, id_ex_we, ex_mem_we,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_bubble,
           fwd_a, fwd_b, dmem_err, stall_count
  );

  modport slave (
    input  if_id_rs, if_id_rt, id_ex_rs, id_ex_rt, id_ex_memread,
           ex_mem_regwrite, ex_mem_rd, mem_wb_regwrite, mem_wb_rd,
           ex_mem_memaccess, dmem_ready, branch_taken,
    output pc_we, if_id_we, id_ex_we, ex_mem_we,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_bubble,
           fwd_a, fwd_b, dmem_err, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_forward_unit.sv
// Combinational EX-stage operand forwarding select for one source register.
module forward_unit
  import pipe_pkg::*;
(
  input  logic [4:0] src,
  input  logic       ex_mem_regwrite,
  input  logic [4:0] ex_mem_rd,
  input  logic       mem_wb_regwrite,
  input  logic [4:0] mem_wb_rd,
  output logic [1:0] fwd
);
  always_comb begin
    fwd = FWD_RF;
    if (ex_mem_regwrite && ex_mem_rd != REG_ZERO && ex_mem_rd == src)
      fwd = FWD_MEM;
    else if (mem_wb_regwrite && mem_wb_rd != REG_ZERO && mem_wb_rd == src)
      fwd = FWD_WB;
  end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: pipeline register enables, flushes,
// forwarding selects and the data-memory wait/timeout state machine.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int unsigned WAIT_W = $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt, wait_inc;
  logic [CNT_W-1:0]  stall_cnt;
  logic              mem_stall, load_use;
  logic              pc_we, if_id_we, id_ex_we, ex_mem_we;
  logic              if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_bubble;
  logic [1:0]        fwd_a_raw, fwd_b_raw;

  assign mem_stall = hz.ex_mem_memaccess && !hz.dmem_ready;
  assign load_use  = hz.id_ex_memread && hz.id_ex_rt != REG_ZERO &&
                     (hz.id_ex_rt == hz.if_id_rs || hz.id_ex_rt == hz.if_id_rt);
  assign wait_inc  = wait_cnt + WAIT_W'(1);

  // Reset is folded into the decode so the pipeline sees hold+flush while rst_n is low.
  always_comb begin
    {pc_we, if_id_we, id_ex_we, ex_mem_we}   = '1;
    {if_id_flush, id_ex_flush, ex_mem_flush} = '0;
    mem_wb_bubble = 1'b0;
    if (!rst_n) begin
      {pc_we, if_id_we, id_ex_we, ex_mem_we}   = '0;
      {if_id_flush, id_ex_flush, ex_mem_flush} = '1;
      mem_wb_bubble = 1'b1;
    end else if (state == ERROR || mem_stall) begin
      {pc_we, if_id_we, id_ex_we, ex_mem_we} = '0;
      mem_wb_bubble = 1'b1;
    end else if (hz.branch_taken) begin
      {if_id_flush, id_ex_flush, ex_mem_flush} = '1;
    end else if (load_use) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // The not-ready cycle seen in RUN counts toward the timeout, hence the
  // comparison on the incremented value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (!pc_we && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      case (state)
        RUN: begin
          wait_cnt <= '0;
          if (mem_stall) state <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (hz.dmem_ready) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_inc == WAIT_LAST) begin
            state <= ERROR;
          end else begin
            wait_cnt <= wait_inc;
          end
        end
        default: ;
      endcase
    end
  end

  forward_unit u_fwd_a (
    .src             (hz.id_ex_rs),
    .ex_mem_regwrite (hz.ex_mem_regwrite),
    .ex_mem_rd       (hz.ex_mem_rd),
    .mem_wb_regwrite (hz.mem_wb_regwrite),
    .mem_wb_rd       (hz.mem_wb_rd),
    .fwd             (fwd_a_raw)
  );

  forward_unit u_fwd_b (
    .src             (hz.id_ex_rt),
    .ex_mem_regwrite (hz.ex_mem_regwrite),
    .ex_mem_rd       (hz.ex_mem_rd),
    .mem_wb_regwrite (hz.mem_wb_regwrite),
    .mem_wb_rd       (hz.mem_wb_rd),
    .fwd             (fwd_b_raw)
  );

  assign hz.pc_we         = pc_we;
  assign hz.if_id_we      = if_id_we;
  assign hz.id_ex_we      = id_ex_we;
  assign hz.ex_mem_we     = ex_mem_we;
  assign hz.if_id_flush   = if_id_flush;
  assign hz.id_ex_flush   = id_ex_flush;
  assign hz.ex_mem_flush  = ex_mem_flush;
  assign hz.mem_wb_bubble = mem_wb_bubble;
  assign hz.fwd_a         = rst_n ? fwd_a_raw : FWD_RF;
  assign hz.fwd_b         = rst_n ? fwd_b_raw : FWD_RF;
  assign hz.dmem_err      = (state == ERROR);
  assign hz.stall_count   = stall_cnt;

endmodule
